mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- FIXED_PRIO, 0, 1 = port 0 always wins ties; 0 = round-robin.

REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock, same clock as the RAM manager.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request, port 0 / port 1.
- be0 / be1  in  4  byte write enables; 0000 = read.
- addr0 / addr1  in  ADDR_W  byte address.
- wdata0 / wdata1  in  DATA_W  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  DATA_W  read data.
- mem_we  out  4  byte write enables to the RAM manager.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after the address is sampled.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  index of the port currently or last granted.

Function
REQ-003 The FSM SHALL have three states (IDLE, ACCESS, RESP) with these transitions:
- IDLE -> ACCESS when any req is high.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.

REQ-004 In IDLE with only one req high, that port SHALL be granted.

REQ-005 In IDLE with both reqs high, the grant SHALL be:
- port 0 when FIXED_PRIO=1;
- otherwise the port not equal to last_owner.

REQ-006 On the IDLE->ACCESS edge, the arbiter SHALL:
- register the winner's addr, wdata and be into mem_addr, mem_wdata and mem_we;
- set owner and last_owner to the winner.

REQ-007 On the ACCESS->RESP edge, mem_we SHALL clear to 0000; mem_addr and mem_wdata SHALL hold their values.

REQ-008 ack[owner] SHALL be high in RESP only, for exactly one cycle; the other ack SHALL stay low.

REQ-009 In RESP, rdata[owner] SHALL equal mem_rdata combinationally.

REQ-010 Outside RESP, each rdataN SHALL hold the value captured at its own last RESP, for reads and writes alike.

REQ-011 Latency: with req seen in IDLE at cycle N, the write SHALL commit at the end of N+1 and ack SHALL be high in N+2.

REQ-012 Throughput SHALL be at most one access per 3 cycles; the guaranteed IDLE cycle after RESP prevents re-granting a requester whose req is still high while acked.

REQ-013 Requester signals SHALL be sampled only in IDLE. A req dropped or changed after grant SHALL NOT abort the transaction, and the ack still pulses.

REQ-014 A req asserted while busy SHALL wait, without loss, until the next IDLE.

REQ-015 With both ports continuously requesting and FIXED_PRIO=0, grants SHALL strictly alternate 0,1,0,1.

REQ-016 When no req is high, the FSM SHALL stay in IDLE with mem_we = 0000.

Reset
REQ-017 When rst is high at a clk edge, the following SHALL be set regardless of current state, including mid-ACCESS:
- state = IDLE, busy = 0, owner = 0, last_owner = 1;
- mem_we = 0000, mem_addr = 0, mem_wdata = 0;
- ack0 = ack1 = 0;
- held rdata0 = rdata1 = 0.

REQ-018 A transaction interrupted by reset SHALL NOT produce an ack after reset is released.

Structure
REQ-019 A shared package SHALL hold the state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the port index constants PORT_CPU=0 and PORT_AUX=1.

REQ-020 Winner selection SHALL be a combinational sub-module, arb_pick, with:
- inputs: req0, req1, last_owner, FIXED_PRIO;
- outputs: grant_valid, grant_idx.

REQ-021 The intended placement SHALL be port 0 = CPU and port 1 = auxiliary loader or display DMA. mem_we SHALL connect directly to the RAM manager's writeEnables.

Verification
REQ-022 Single write: req0=1, be0=1111, addr0=0x10, wdata0=0xDEADBEEF at cycle 1 -> the bench SHALL observe:
- mem_we=1111 and mem_addr=0x10 in cycle 2;
- ack0 high in cycle 3 only;
- ack1 never asserted.

REQ-023 Read-back: after REQ-022, req1=1, be1=0000, addr1=0x10 -> the bench SHALL observe:
- ack1 pulses with rdata1=0xDEADBEEF;
- rdata1 still holds 0xDEADBEEF 5 cycles later.

REQ-024 Contention, FIXED_PRIO=0: both reqs held high for 12 cycles -> the bench SHALL observe 4 grants in order 0,1,0,1, with acks 3 cycles apart.

REQ-025 Contention, FIXED_PRIO=1: both reqs held high -> the bench SHALL observe that every grant goes to port 0 and ack1 never asserts.

REQ-026 Reset mid-operation: rst=1 during ACCESS of a be0=0011 write -> the bench SHALL observe, in the next cycle:
- mem_we=0000, busy=0;
- no ack0 pulse afterwards;
- the next tie granted to port 0.

REQ-027 Partial write: be0=0100, wdata0=0x00AB0000 -> mem_we=0100 for exactly one cycle; a later read of the same address SHALL show only byte 2 changed.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester port indices and a small helper for round-robin selection.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Port 0 is the CPU, port 1 is the auxiliary loader / display DMA.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Index of the port that is not 'idx'.
  function automatic logic other_port(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles both requester ports and the RAM-manager side of the arbiter.
//   req0/req1, be0/be1, addr0/addr1, wdata0/wdata1 : requester inputs
//   ack0/ack1, rdata0/rdata1                       : requester responses
//   mem_we, mem_addr, mem_wdata / mem_rdata        : RAM manager bus
//   busy, owner                                    : arbiter status
// Modport slave is the arbiter's view; master is the environment's view
// (requesters plus RAM manager).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              req0;
  logic              req1;
  logic [3:0]        be0;
  logic [3:0]        be1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;

  modport slave (
    input  req0, req1, be0, be1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output req0, req1, be0, be1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, mem_we, mem_addr, mem_wdata, busy, owner
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick
// Combinational winner selection for the two-port arbiter.
//   req0, req1   : pending requests
//   last_owner   : port granted most recently
//   fixed_prio   : 1 = port 0 always wins a tie, 0 = alternate on ties
//   grant_valid  : at least one request is pending
//   grant_idx    : index of the winning port
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  input  logic fixed_prio,
  output logic grant_valid,
  output logic grant_idx
);

  // A tie goes to the CPU under fixed priority, otherwise to whichever
  // port did not win last time so both ports alternate.
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = PORT_CPU;
    if (req0 && req1) begin
      grant_idx = fixed_prio ? PORT_CPU : other_port(last_owner);
    end else if (req1) begin
      grant_idx = PORT_AUX;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port arbiter in front of a single-cycle RAM manager. Each access
// takes IDLE -> ACCESS -> RESP; the RAM sees the address and byte enables
// during ACCESS and returns read data during RESP.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mem_arbiter_if.slave (requester ports, RAM bus, status)
//   Parameters: ADDR_W, DATA_W, FIXED_PRIO (1 = port 0 wins ties)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);

  state_t            state;
  logic              owner_q;
  logic              last_owner;
  logic              busy_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [3:0]        mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] held0;
  logic [DATA_W-1:0] held1;

  logic              grant_valid;
  logic              grant_idx;
  logic [3:0]        win_be;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  arb_pick u_pick (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last_owner  (last_owner),
    .fixed_prio  (FIXED_PRIO),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign win_be    = (grant_idx == PORT_AUX) ? bus.be1    : bus.be0;
  assign win_addr  = (grant_idx == PORT_AUX) ? bus.addr1  : bus.addr0;
  assign win_wdata = (grant_idx == PORT_AUX) ? bus.wdata1 : bus.wdata0;

  // Requester inputs are only looked at in IDLE, so a requester may drop
  // or change its request after the grant without disturbing the access.
  // The ack is registered on the ACCESS->RESP edge, and the read data is
  // latched into the owner's holding register on the way out of RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      owner_q     <= PORT_CPU;
      last_owner  <= PORT_AUX;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      held0       <= '0;
      held1       <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack0_q   <= 1'b0;
          ack1_q   <= 1'b0;
          mem_we_q <= 4'b0000;
          if (grant_valid) begin
            state       <= ACCESS;
            busy_q      <= 1'b1;
            mem_we_q    <= win_be;
            mem_addr_q  <= win_addr;
            mem_wdata_q <= win_wdata;
            owner_q     <= grant_idx;
            last_owner  <= grant_idx;
          end
        end
        ACCESS: begin
          state    <= RESP;
          mem_we_q <= 4'b0000;
          ack0_q   <= (owner_q == PORT_CPU);
          ack1_q   <= (owner_q == PORT_AUX);
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          if (owner_q == PORT_CPU) begin
            held0 <= bus.mem_rdata;
          end else begin
            held1 <= bus.mem_rdata;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // During RESP the owner sees the RAM data directly; otherwise each port
  // keeps showing what it captured at its own last response.
  assign bus.rdata0 = ack0_q ? bus.mem_rdata : held0;
  assign bus.rdata1 = ack1_q ? bus.mem_rdata : held1;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives a round-robin arbiter (index 0) and a fixed-priority arbiter
// (index 1) side by side, each with its own small RAM. A transaction-level
// reference model predicts each grant, its response cycle and its read
// data; a monitor pops those predictions whenever an ack appears.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NTX = 30;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus, indexed [dut][port]
  logic          req   [2][2];
  logic [3:0]    be    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];

  // Observed outputs
  logic          ack_w    [2][2];
  logic [DW-1:0] rdata_w  [2][2];
  logic          busy_w   [2];
  logic          owner_w  [2];
  logic [3:0]    mem_we_w [2];
  logic [AW-1:0] mem_addr_w [2];

  exp_t        exp_q   [2][$];
  int          ack_log [2][$];
  int unsigned ack_cyc [2][$];
  logic [31:0] shadow  [2][8];
  logic        rst_edge[2];
  bit          rand_go  = 1'b0;
  int          done_cnt = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : gen_dut
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(d == 1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    assign bus.req0   = req[d][0];
    assign bus.req1   = req[d][1];
    assign bus.be0    = be[d][0];
    assign bus.be1    = be[d][1];
    assign bus.addr0  = addr[d][0];
    assign bus.addr1  = addr[d][1];
    assign bus.wdata0 = wdata[d][0];
    assign bus.wdata1 = wdata[d][1];
    assign ack_w[d][0]   = bus.ack0;
    assign ack_w[d][1]   = bus.ack1;
    assign rdata_w[d][0] = bus.rdata0;
    assign rdata_w[d][1] = bus.rdata1;
    assign busy_w[d]     = bus.busy;
    assign owner_w[d]    = bus.owner;
    assign mem_we_w[d]   = bus.mem_we;
    assign mem_addr_w[d] = bus.mem_addr;

    // Eight-word RAM with registered read-first data, cleared by reset.
    logic [31:0] ram [8];
    logic [31:0] ram_rdata;
    assign bus.mem_rdata = ram_rdata;

    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) ram[i] <= '0;
        ram_rdata <= '0;
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_we[b]) ram[bus.mem_addr[4:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        ram_rdata <= ram[bus.mem_addr[4:2]];
      end
    end

    // Reference model: one access per three cycles, ties by priority rule.
    int   busy_left;
    logic last;
    always @(posedge clk) begin
      int          w;
      logic [2:0]  idx;
      exp_t        e;
      rst_edge[d] = rst;
      if (rst) begin
        exp_q[d].delete();
        busy_left = 0;
        last = 1'b1;
        for (int i = 0; i < 8; i++) shadow[d][i] = '0;
      end else if (busy_left > 0) begin
        busy_left--;
      end else if (req[d][0] || req[d][1]) begin
        if (req[d][0] && req[d][1]) w = (d == 1) ? 0 : (last ? 0 : 1);
        else w = req[d][1] ? 1 : 0;
        last    = w[0];
        idx     = addr[d][w][4:2];
        e.port  = w;
        e.rdata = shadow[d][idx];
        e.cyc   = cyc + 2;
        for (int b = 0; b < 4; b++)
          if (be[d][w][b]) shadow[d][idx][8*b +: 8] = wdata[d][w][8*b +: 8];
        exp_q[d].push_back(e);
        busy_left = 2;
      end
    end

    // Monitor: reset state, acks against predictions, held read data.
    logic [31:0] held [2];
    always @(negedge clk) begin
      exp_t e;
      if (rst_edge[d]) begin
        held[0] = '0;
        held[1] = '0;
        checkOutput("rst_busy", 64'(bus.busy), 64'(0));
        checkOutput("rst_owner", 64'(bus.owner), 64'(0));
        checkOutput("rst_mem_we", 64'(bus.mem_we), 64'(0));
        checkOutput("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        checkOutput("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
      end
      if (bus.ack0 || bus.ack1) begin
        if (exp_q[d].size() == 0) begin
          checkOutput("spurious_ack", 64'({bus.ack1, bus.ack0}), 64'(0));
        end else begin
          e = exp_q[d].pop_front();
          checkOutput("ack_port", 64'(bus.ack1 ? 1 : 0), 64'(e.port));
          checkOutput("ack_single", 64'(bus.ack0 & bus.ack1), 64'(0));
          checkOutput("ack_cycle", 64'(cyc), 64'(e.cyc));
          checkOutput("resp_rdata", 64'(e.port == 1 ? bus.rdata1 : bus.rdata0), 64'(e.rdata));
          held[e.port] = e.rdata;
          ack_log[d].push_back(e.port);
          ack_cyc[d].push_back(cyc);
        end
      end
      if (!bus.ack0) checkOutput("rdata0_hold", 64'(bus.rdata0), 64'(held[0]));
      if (!bus.ack1) checkOutput("rdata1_hold", 64'(bus.rdata1), 64'(held[1]));
      if (!bus.busy) begin
        checkOutput("idle_mem_we", 64'(bus.mem_we), 64'(0));
        checkOutput("idle_ack", 64'({bus.ack1, bus.ack0}), 64'(0));
      end
    end

    // Random requesters: hold req until acked, sometimes drop or scramble
    // the request fields right after being granted.
    for (genvar p = 0; p < 2; p++) begin : gen_port
      initial begin
        bit granted;
        bit got;
        wait (rand_go);
        repeat (NTX) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          @(posedge clk);
          #1;
          be[d][p]    = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom);
          addr[d][p]  = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
          wdata[d][p] = $urandom;
          req[d][p]   = 1'b1;
          granted = 1'b0;
          got     = 1'b0;
          for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk);
            #1;
            if (!granted && busy_w[d] && owner_w[d] == p[0]) begin
              granted = 1'b1;
              if ($urandom_range(0, 1) == 1) begin
                req[d][p]   = 1'b0;
                addr[d][p]  = $urandom;
                wdata[d][p] = $urandom;
                be[d][p]    = 4'($urandom);
              end
            end
            if (ack_w[d][p]) got = 1'b1;
          end
          req[d][p] = 1'b0;
          checkOutput("ack_within_bound", 64'(got), 64'(1));
        end
        done_cnt++;
      end
    end
  end

  task automatic waitIdle();
    bit ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!busy_w[0] && !busy_w[1]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("wait_idle", 64'(ok), 64'(1));
  endtask

  // Present one request on both arbiters in IDLE; returns in ACCESS.
  task automatic applyStimulus(input int p, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] w);
    waitIdle();
    for (int d = 0; d < 2; d++) begin
      req[d][p] = 1'b1; be[d][p] = b; addr[d][p] = a; wdata[d][p] = w;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) req[d][p] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0; be[d][p] = '0; addr[d][p] = '0; wdata[d][p] = '0;
      end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] single write");
    applyStimulus(0, 4'hF, 32'h10, 32'hDEADBEEF);
    for (int d = 0; d < 2; d++) begin
      checkOutput("wr_mem_we", 64'(mem_we_w[d]), 64'(4'hF));
      checkOutput("wr_mem_addr", 64'(mem_addr_w[d]), 64'(32'h10));
      checkOutput("wr_busy", 64'(busy_w[d]), 64'(1));
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("wr_ack0", 64'(ack_w[d][0]), 64'(1));
      checkOutput("wr_ack1", 64'(ack_w[d][1]), 64'(0));
      checkOutput("resp_mem_we", 64'(mem_we_w[d]), 64'(0));
      checkOutput("resp_mem_addr", 64'(mem_addr_w[d]), 64'(32'h10));
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) checkOutput("wr_ack0_end", 64'(ack_w[d][0]), 64'(0));

    $display("[TB] read back");
    applyStimulus(1, 4'b0000, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("rd_ack1", 64'(ack_w[d][1]), 64'(1));
      checkOutput("rd_rdata1", 64'(rdata_w[d][1]), 64'(32'hDEADBEEF));
    end
    repeat (5) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) checkOutput("rd_rdata1_later", 64'(rdata_w[d][1]), 64'(32'hDEADBEEF));

    $display("[TB] partial write");
    applyStimulus(0, 4'b0100, 32'h10, 32'h00AB0000);
    for (int d = 0; d < 2; d++) checkOutput("pw_mem_we", 64'(mem_we_w[d]), 64'(4'b0100));
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) checkOutput("pw_mem_we_clear", 64'(mem_we_w[d]), 64'(0));
    applyStimulus(1, 4'b0000, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) checkOutput("pw_readback", 64'(rdata_w[d][1]), 64'(32'hDEABBEEF));

    $display("[TB] contention");
    waitIdle();
    for (int d = 0; d < 2; d++) begin
      ack_log[d].delete();
      ack_cyc[d].delete();
      be[d][0] = 4'hF; addr[d][0] = 32'h4; wdata[d][0] = $urandom;
      be[d][1] = 4'h0; addr[d][1] = 32'h8; wdata[d][1] = $urandom;
      req[d][0] = 1'b1; req[d][1] = 1'b1;
    end
    repeat (12) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      req[d][0] = 1'b0; req[d][1] = 1'b0;
    end
    waitIdle();
    for (int d = 0; d < 2; d++) begin
      checkOutput("cont_grants", 64'(ack_log[d].size()), 64'(4));
      for (int i = 0; i < ack_log[d].size() && i < 4; i++) begin
        checkOutput("cont_order", 64'(ack_log[d][i]), 64'(d == 1 ? 0 : i % 2));
        if (i > 0) checkOutput("cont_spacing", 64'(ack_cyc[d][i] - ack_cyc[d][i-1]), 64'(3));
      end
    end

    $display("[TB] reset during access");
    for (int d = 0; d < 2; d++) ack_log[d].delete();
    applyStimulus(0, 4'b0011, 32'h8, 32'h12345678);
    for (int d = 0; d < 2; d++) checkOutput("rs_mem_we", 64'(mem_we_w[d]), 64'(4'b0011));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checkOutput("rs_busy", 64'(busy_w[d]), 64'(0));
      checkOutput("rs_mem_we_clear", 64'(mem_we_w[d]), 64'(0));
    end
    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("rs_no_ack", 64'(ack_log[d].size()), 64'(0));
      req[d][0] = 1'b1; be[d][0] = 4'h0; addr[d][0] = 32'h0;
      req[d][1] = 1'b1; be[d][1] = 4'h0; addr[d][1] = 32'h0;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      req[d][0] = 1'b0; req[d][1] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("rs_tie_count", 64'(ack_log[d].size()), 64'(1));
      if (ack_log[d].size() > 0) checkOutput("rs_tie_port", 64'(ack_log[d][0]), 64'(0));
    end

    $display("[TB] random traffic");
    rand_go = 1'b1;
    for (int k = 0; k < 20000 && done_cnt < 4; k++) @(posedge clk);
    checkOutput("random_done", 64'(done_cnt), 64'(4));
    repeat (5) @(posedge clk);
    for (int d = 0; d < 2; d++) checkOutput("queue_drained", 64'(exp_q[d].size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
